// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, default word/idle settings
// and a parity helper reused by the RX checker.
package uart_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  localparam int   UART_DATA_W   = 8;
  localparam logic UART_IDLE_LVL = 1'b1;
  localparam int   UART_MAX_W    = 16;

  // Even parity of the word, inverted for odd parity; narrower words are zero-extended.
  function automatic logic uart_parity(input logic [UART_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_p.sv
// Parametrised UART TX parallel-to-serial shifter with valid/ready load and TICK pacing.
// Optional parity bit after the data bits when UART_TX_SER_PARITY_EN is defined.
module uart_tx_serializer_p
  import uart_pkg::*;
#(
  parameter int   DATA_W    = UART_DATA_W,
  parameter int   MSB_FIRST = 0,
  parameter logic IDLE_LVL  = UART_IDLE_LVL
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TICK,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [DATA_W-1:0] P_DATA,
`ifdef UART_TX_SER_PARITY_EN
  input  logic              PAR_ODD,
`endif
  output logic              SERIAL_DATA,
  output logic              SER_DONE,
  output logic              BUSY
);

`ifdef UART_TX_SER_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int               CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_BITS);

  ser_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              ser_q, ser_d;
  logic              done_q, done_d;
`ifdef UART_TX_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ser_q   <= IDLE_LVL;
      done_q  <= 1'b0;
`ifdef UART_TX_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
`ifdef UART_TX_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SER_IDLE:  if (LD_VALID) state_d = SER_SHIFT;
      SER_SHIFT: if (TICK && (cnt_q == CNT_DONE)) state_d = SER_IDLE;
      default:   state_d = SER_IDLE;
    endcase
  end

  // Datapath: a bit leaves the register on each TICK; the TICK after the last bit ends the frame.
  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    ser_d  = ser_q;
    done_d = 1'b0;
`ifdef UART_TX_SER_PARITY_EN
    par_d  = par_q;
`endif
    unique case (state_q)
      SER_IDLE: begin
        if (LD_VALID) begin
          sh_d  = P_DATA;
          cnt_d = '0;
`ifdef UART_TX_SER_PARITY_EN
          par_d = uart_parity(UART_MAX_W'(P_DATA), PAR_ODD);
`endif
        end
      end
      SER_SHIFT: begin
        if (TICK) begin
          if (cnt_q == CNT_DONE) begin
            ser_d  = IDLE_LVL;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q < CNT_DATA) begin
              ser_d = (MSB_FIRST != 0) ? sh_q[DATA_W-1] : sh_q[0];
              sh_d  = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
            end
`ifdef UART_TX_SER_PARITY_EN
            else begin
              ser_d = par_q;
            end
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    LD_READY    = (state_q == SER_IDLE);
    BUSY        = (state_q == SER_SHIFT);
    SERIAL_DATA = ser_q;
    SER_DONE    = done_q;
  end

endmodule

// File: tb/tb_uart_tx_serializer_p.sv
// Directed bench for uart_tx_serializer_p: LSB/MSB-first 8-bit instances plus a 1-bit instance.
// Parity expectations are added when UART_TX_SER_PARITY_EN is defined.
module tb_uart_tx_serializer_p;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       ld_valid = 1'b0;
  logic       ld_valid1 = 1'b0;
  logic       par_odd = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic [0:0] p_data1 = 1'b0;

  logic ser_l, done_l, busy_l, rdy_l;
  logic ser_m, done_m, busy_m, rdy_m;
  logic ser_1, done_1, busy_1, rdy_1;

  int total = 0;
  int bad = 0;
  int n_done_l = 0;
  int n_done_m = 0;
  int n_done_1 = 0;

`ifdef UART_TX_SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  always #5 clk = ~clk;

  uart_tx_serializer_p #(.DATA_W(8), .MSB_FIRST(0), .IDLE_LVL(1'b1)) dut_l (
    .CLK(clk), .RST(rst_n), .TICK(tick), .LD_VALID(ld_valid), .LD_READY(rdy_l),
    .P_DATA(p_data),
`ifdef UART_TX_SER_PARITY_EN
    .PAR_ODD(par_odd),
`endif
    .SERIAL_DATA(ser_l), .SER_DONE(done_l), .BUSY(busy_l)
  );

  uart_tx_serializer_p #(.DATA_W(8), .MSB_FIRST(1), .IDLE_LVL(1'b1)) dut_m (
    .CLK(clk), .RST(rst_n), .TICK(tick), .LD_VALID(ld_valid), .LD_READY(rdy_m),
    .P_DATA(p_data),
`ifdef UART_TX_SER_PARITY_EN
    .PAR_ODD(par_odd),
`endif
    .SERIAL_DATA(ser_m), .SER_DONE(done_m), .BUSY(busy_m)
  );

  uart_tx_serializer_p #(.DATA_W(1), .MSB_FIRST(0), .IDLE_LVL(1'b1)) dut_1 (
    .CLK(clk), .RST(rst_n), .TICK(tick), .LD_VALID(ld_valid1), .LD_READY(rdy_1),
    .P_DATA(p_data1),
`ifdef UART_TX_SER_PARITY_EN
    .PAR_ODD(par_odd),
`endif
    .SERIAL_DATA(ser_1), .SER_DONE(done_1), .BUSY(busy_1)
  );

  always @(negedge clk) begin
    if (done_l === 1'b1) n_done_l++;
    if (done_m === 1'b1) n_done_m++;
    if (done_1 === 1'b1) n_done_1++;
  end

  // Expected line value for frame position i: data bit in the chosen order, then parity.
  function automatic logic exp_bit(input logic [7:0] d, input int i, input bit msb, input logic odd);
    if (i < 8) return msb ? d[7-i] : d[i];
    return (^d) ^ odd;
  endfunction

  // One clock edge with TICK at the given level; returns 1 time unit after the edge.
  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step(1'b0);
    total++;
    if (ser_l !== 1'b1 || rdy_l !== 1'b1 || busy_l !== 1'b0 || done_l !== 1'b0 ||
        ser_m !== 1'b1 || rdy_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: ser=%b%b rdy=%b%b busy=%b%b done=%b%b required ser=11 rdy=11 busy=00 done=00",
               ser_l, ser_m, rdy_l, rdy_m, busy_l, busy_m, done_l, done_m);
    end
    step(1'b1);
    total++;
    if (ser_l !== 1'b1 || busy_l !== 1'b0 || ser_1 !== 1'b1 || rdy_1 !== 1'b1 || busy_1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick: ser_l=%b busy_l=%b ser_1=%b rdy_1=%b busy_1=%b required 1 0 1 1 0",
               ser_l, busy_l, ser_1, rdy_1, busy_1);
    end
    rst_n = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    total++;
    if (ser_l !== 1'b1 || rdy_l !== 1'b1 || busy_l !== 1'b0 || done_l !== 1'b0 ||
        ser_m !== 1'b1 || busy_m !== 1'b0 || n_done_l != 0 || n_done_m != 0) begin
      bad++;
      $display("FAIL idle_tick: ser_l=%b rdy_l=%b busy_l=%b done_l=%b ser_m=%b busy_m=%b dones=%0d/%0d required 1 1 0 0 1 0 0/0",
               ser_l, rdy_l, busy_l, done_l, ser_m, busy_m, n_done_l, n_done_m);
    end
  endtask

  task automatic test_shift_orders(input logic odd);
    int   nl, nm;
    logic el, em;
    nl = n_done_l;
    nm = n_done_m;
    par_odd = odd;
    p_data = 8'h0B;
    ld_valid = 1'b1;
    step(1'b0);
    ld_valid = 1'b0;
    p_data = 8'hFF;
    par_odd = ~odd;
    total++;
    if (busy_l !== 1'b1 || rdy_l !== 1'b0 || ser_l !== 1'b1 || busy_m !== 1'b1 || ser_m !== 1'b1) begin
      bad++;
      $display("FAIL load: busy_l=%b rdy_l=%b ser_l=%b busy_m=%b ser_m=%b required 1 0 1 1 1",
               busy_l, rdy_l, ser_l, busy_m, ser_m);
    end
    for (int b = 0; b < NB; b++) begin
      el = exp_bit(8'h0B, b, 1'b0, odd);
      em = exp_bit(8'h0B, b, 1'b1, odd);
      step(1'b1);
      for (int c = 0; c < 16; c++) begin
        total++;
        if (ser_l !== el || ser_m !== em) begin
          bad++;
          $display("FAIL bit%0d_cyc%0d: lsb=%b msb=%b required lsb=%b msb=%b", b, c, ser_l, ser_m, el, em);
        end
        if (c < 15) step(1'b0);
      end
    end
    step(1'b1);
    total++;
    if (ser_l !== 1'b1 || done_l !== 1'b1 || busy_l !== 1'b0 || rdy_l !== 1'b1 ||
        ser_m !== 1'b1 || done_m !== 1'b1) begin
      bad++;
      $display("FAIL frame_end: ser_l=%b done_l=%b busy_l=%b rdy_l=%b ser_m=%b done_m=%b required 1 1 0 1 1 1",
               ser_l, done_l, busy_l, rdy_l, ser_m, done_m);
    end
    step(1'b0);
    total++;
    if (done_l !== 1'b0 || done_m !== 1'b0 || n_done_l != nl + 1 || n_done_m != nm + 1) begin
      bad++;
      $display("FAIL done_once: done=%b%b count_l=%0d count_m=%0d required 00 %0d %0d",
               done_l, done_m, n_done_l, n_done_m, nl + 1, nm + 1);
    end
  endtask

  task automatic test_back_to_back();
    int   nl;
    logic el, em;
    logic [7:0] d;
    nl = n_done_l;
    par_odd = 1'b0;
    p_data = 8'h0B;
    ld_valid = 1'b1;
    step(1'b0);
    p_data = 8'hF0;
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 8'h0B : 8'hF0;
      for (int b = 0; b < NB; b++) begin
        el = exp_bit(d, b, 1'b0, 1'b0);
        em = exp_bit(d, b, 1'b1, 1'b0);
        step(1'b1);
        total++;
        if (ser_l !== el || ser_m !== em || busy_l !== 1'b1) begin
          bad++;
          $display("FAIL b2b_f%0d_bit%0d: lsb=%b msb=%b busy=%b required lsb=%b msb=%b busy=1",
                   f, b, ser_l, ser_m, busy_l, el, em);
        end
        step(1'b0);
        step(1'b0);
      end
      step(1'b1);
      total++;
      if (done_l !== 1'b1 || rdy_l !== 1'b1 || ser_l !== 1'b1) begin
        bad++;
        $display("FAIL b2b_done_f%0d: done=%b rdy=%b ser=%b required 1 1 1", f, done_l, rdy_l, ser_l);
      end
      step(1'b0);
      if (f == 0) begin
        ld_valid = 1'b0;
        total++;
        if (busy_l !== 1'b1 || busy_m !== 1'b1 || ser_l !== 1'b1) begin
          bad++;
          $display("FAIL b2b_reload: busy_l=%b busy_m=%b ser=%b required 1 1 1", busy_l, busy_m, ser_l);
        end
      end
    end
    total++;
    if (n_done_l != nl + 2 || busy_l !== 1'b0) begin
      bad++;
      $display("FAIL b2b_count: dones=%0d busy=%b required %0d 0", n_done_l - nl, busy_l, 2);
    end
  endtask

  task automatic test_mid_reset();
    int   nl;
    logic el;
    nl = n_done_l;
    par_odd = 1'b0;
    p_data = 8'h0B;
    ld_valid = 1'b1;
    step(1'b0);
    ld_valid = 1'b0;
    repeat (3) begin
      step(1'b1);
      step(1'b0);
    end
    total++;
    if (ser_l !== 1'b0 || ser_m !== 1'b0 || busy_l !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: lsb=%b msb=%b busy=%b required 0 0 1", ser_l, ser_m, busy_l);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ser_l !== 1'b1 || busy_l !== 1'b0 || rdy_l !== 1'b1 || ser_m !== 1'b1 || busy_m !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: ser_l=%b busy_l=%b rdy_l=%b ser_m=%b busy_m=%b required 1 0 1 1 0",
               ser_l, busy_l, rdy_l, ser_m, busy_m);
    end
    step(1'b1);
    rst_n = 1'b1;
    step(1'b1);
    total++;
    if (n_done_l != nl || busy_l !== 1'b0 || ser_l !== 1'b1) begin
      bad++;
      $display("FAIL mid_nodone: dones=%0d busy=%b ser=%b required %0d 0 1", n_done_l, busy_l, ser_l, nl);
    end
    p_data = 8'hF0;
    ld_valid = 1'b1;
    step(1'b0);
    ld_valid = 1'b0;
    for (int b = 0; b < NB; b++) begin
      el = exp_bit(8'hF0, b, 1'b0, 1'b0);
      step(1'b1);
      total++;
      if (ser_l !== el || ser_m !== exp_bit(8'hF0, b, 1'b1, 1'b0)) begin
        bad++;
        $display("FAIL mid_new_bit%0d: lsb=%b msb=%b required lsb=%b msb=%b",
                 b, ser_l, ser_m, el, exp_bit(8'hF0, b, 1'b1, 1'b0));
      end
      step(1'b0);
    end
    step(1'b1);
    total++;
    if (done_l !== 1'b1 || ser_l !== 1'b1 || n_done_l != nl) begin
      bad++;
      $display("FAIL mid_new_done: done=%b ser=%b prior_dones=%0d required 1 1 %0d", done_l, ser_l, n_done_l, nl);
    end
    step(1'b0);
  endtask

  task automatic test_width1();
    int n1;
    n1 = n_done_1;
    p_data1 = 1'b0;
    ld_valid1 = 1'b1;
    step(1'b0);
    ld_valid1 = 1'b0;
    p_data1 = 1'b1;
    total++;
    if (busy_1 !== 1'b1 || ser_1 !== 1'b1) begin
      bad++;
      $display("FAIL w1_load: busy=%b ser=%b required 1 1", busy_1, ser_1);
    end
    step(1'b1);
    total++;
    if (ser_1 !== 1'b0 || done_1 !== 1'b0) begin
      bad++;
      $display("FAIL w1_bit: ser=%b done=%b required 0 0", ser_1, done_1);
    end
`ifdef UART_TX_SER_PARITY_EN
    step(1'b1);
    total++;
    if (ser_1 !== 1'b0 || done_1 !== 1'b0) begin
      bad++;
      $display("FAIL w1_parity: ser=%b done=%b required 0 0", ser_1, done_1);
    end
`endif
    step(1'b1);
    total++;
    if (ser_1 !== 1'b1 || done_1 !== 1'b1 || busy_1 !== 1'b0 || rdy_1 !== 1'b1) begin
      bad++;
      $display("FAIL w1_done: ser=%b done=%b busy=%b rdy=%b required 1 1 0 1", ser_1, done_1, busy_1, rdy_1);
    end
    step(1'b0);
    total++;
    if (n_done_1 != n1 + 1) begin
      bad++;
      $display("FAIL w1_count: dones=%0d required %0d", n_done_1, n1 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_shift_orders(1'b0);
`ifdef UART_TX_SER_PARITY_EN
    test_shift_orders(1'b1);
`endif
    test_back_to_back();
    test_mid_reset();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
